// File: rtl/launchpad_color_mapper_pkg.sv
// Shared types for the pad-grid colour mapper: brightness level type, RGB triple
// and the per-row red-to-green base colour.
package launchpad_pkg;

  localparam int LEVEL_W = 4;
  localparam logic [LEVEL_W-1:0] LMAX = '1;

  typedef logic [LEVEL_W-1:0] level_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic rgb_t row_base(input int row, input int v_pads);
    int   g;
    rgb_t c;
    g   = (row * 255) / (v_pads - 1);
    c.r = 8'(255 - g);
    c.g = 8'(g);
    c.b = 8'd0;
    return c;
  endfunction

endpackage

// File: rtl/launchpad_color_mapper_if.sv
// Pixel-side bus of the colour mapper: VGA coordinates, frame tick, pad levels in,
// DAC colour channels out.
interface launchpad_color_mapper_if #(
  parameter int NPADS = 64
);
  logic             frame_start;
  logic [9:0]       DrawX;
  logic [9:0]       DrawY;
  logic [NPADS-1:0] pad_in;
  logic [7:0]       VGA_R;
  logic [7:0]       VGA_G;
  logic [7:0]       VGA_B;

  modport master (
    output frame_start, DrawX, DrawY, pad_in,
    input  VGA_R, VGA_G, VGA_B
  );

  modport slave (
    input  frame_start, DrawX, DrawY, pad_in,
    output VGA_R, VGA_G, VGA_B
  );
endinterface

// File: rtl/launchpad_color_mapper_pad_level_bank.sv
// Per-pad brightness levels: a press loads full brightness, and every DECAY_FRAMES
// frames each released pad dims by one step down to zero.
module pad_level_bank #(
  parameter int NPADS        = 64,
  parameter int LEVEL_W      = 4,
  parameter int DECAY_FRAMES = 4,
  parameter int IDX_W        = $clog2(NPADS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic [NPADS-1:0]   pad_in,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [LEVEL_W-1:0] rd_level
);
  localparam int FCNT_W = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;

  logic [LEVEL_W-1:0] level_q [NPADS];
  logic [FCNT_W-1:0]  fcnt_q;
  logic               decay;

  assign decay = frame_start && (fcnt_q == FCNT_W'(DECAY_FRAMES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              fcnt_q <= '0;
    else if (frame_start) fcnt_q <= decay ? '0 : fcnt_q + 1'b1;
  end

  // A press outranks a decay step landing in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NPADS; i++) level_q[i] <= '0;
    end else begin
      for (int i = 0; i < NPADS; i++) begin
        if (pad_in[i])                        level_q[i] <= '1;
        else if (decay && (level_q[i] != '0)) level_q[i] <= level_q[i] - 1'b1;
      end
    end
  end

  assign rd_level = level_q[rd_idx];

endmodule

// File: rtl/launchpad_color_mapper.sv
// Two-stage pixel colour generator for the pad grid. Define LAUNCHPAD_COLOR_MAPPER_FADE_EN
// to get fading per-pad levels; otherwise a pad is full brightness only while pressed.
module launchpad_color_mapper #(
  parameter int H_PADS       = 8,
  parameter int V_PADS       = 8,
  parameter int PAD_SHIFT    = 5,
  parameter int GAP          = 2,
  parameter int ORIGIN_X     = 192,
  parameter int ORIGIN_Y     = 112,
  parameter int LEVEL_W      = 4,
  parameter int DECAY_FRAMES = 4
) (
  input  logic                     Clk,
  input  logic                     Reset,
  launchpad_color_mapper_if.slave  bus
);
  import launchpad_pkg::*;

  localparam int NPADS = H_PADS * V_PADS;
  localparam int IDX_W = $clog2(NPADS);
  localparam int RW    = $clog2(V_PADS);
  localparam int CW    = (H_PADS > 1) ? $clog2(H_PADS) : 1;
  localparam logic [PAD_SHIFT-1:0] GAP_V  = PAD_SHIFT'(GAP);
  localparam logic [LEVEL_W-1:0]   LMAX_V = '1;

  function automatic logic [7:0] scale_ch(input logic [7:0] base, input logic [LEVEL_W-1:0] lvl);
    logic [LEVEL_W+8:0] prod;
    prod = (LEVEL_W+9)'(base) * (LEVEL_W+9)'({1'b0, lvl} + 1'b1);
    return (lvl == '0) ? 8'd0 : prod[LEVEL_W+7:LEVEL_W];
  endfunction

  rgb_t base_lut [V_PADS];
  for (genvar r = 0; r < V_PADS; r++) begin : g_base
    assign base_lut[r] = row_base(r, V_PADS);
  end

  // Stage 0: grid hit and gap test on the incoming pixel
  logic [9:0]       dx_p0, dy_p0, col_full_p0, row_full_p0;
  logic             in_pad_p0;
  logic [CW-1:0]    col_p0;
  logic [RW-1:0]    row_p0;

  always_comb begin
    dx_p0       = bus.DrawX - 10'(ORIGIN_X);
    dy_p0       = bus.DrawY - 10'(ORIGIN_Y);
    col_full_p0 = dx_p0 >> PAD_SHIFT;
    row_full_p0 = dy_p0 >> PAD_SHIFT;
    in_pad_p0   = (col_full_p0 < 10'(H_PADS)) && (row_full_p0 < 10'(V_PADS)) &&
                  (dx_p0[PAD_SHIFT-1:0] >= GAP_V) && (dy_p0[PAD_SHIFT-1:0] >= GAP_V);
    col_p0      = CW'(col_full_p0);
    row_p0      = RW'(row_full_p0);
  end

  // Stage 1: registered pad coordinates
  logic          in_pad_p1;
  logic [CW-1:0] col_p1;
  logic [RW-1:0] row_p1;
  logic [IDX_W-1:0] idx_p1;
  logic [LEVEL_W-1:0] level_p1;

  assign idx_p1 = IDX_W'(row_p1) * IDX_W'(H_PADS) + IDX_W'(col_p1);

`ifdef LAUNCHPAD_COLOR_MAPPER_FADE_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      in_pad_p1 <= 1'b0;
      col_p1    <= '0;
      row_p1    <= '0;
    end else begin
      in_pad_p1 <= in_pad_p0;
      col_p1    <= col_p0;
      row_p1    <= row_p0;
    end
  end

  pad_level_bank #(
    .NPADS        (NPADS),
    .LEVEL_W      (LEVEL_W),
    .DECAY_FRAMES (DECAY_FRAMES),
    .IDX_W        (IDX_W)
  ) u_bank (
    .clk         (Clk),
    .rst         (Reset),
    .frame_start (bus.frame_start),
    .pad_in      (bus.pad_in),
    .rd_idx      (idx_p1),
    .rd_level    (level_p1)
  );
`else
  // The pressed bit travels with the pixel so pad changes also take two cycles
  logic [IDX_W-1:0] idx_p0;
  logic             pad_bit_p1;
  logic             unused_fade;

  assign idx_p0      = IDX_W'(row_p0) * IDX_W'(H_PADS) + IDX_W'(col_p0);
  assign unused_fade = ^{bus.frame_start, idx_p1};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      in_pad_p1  <= 1'b0;
      col_p1     <= '0;
      row_p1     <= '0;
      pad_bit_p1 <= 1'b0;
    end else begin
      in_pad_p1  <= in_pad_p0;
      col_p1     <= col_p0;
      row_p1     <= row_p0;
      pad_bit_p1 <= in_pad_p0 && bus.pad_in[idx_p0];
    end
  end

  assign level_p1 = pad_bit_p1 ? LMAX_V : '0;
`endif

  // Stage 2: brightness scaling into the output registers
  rgb_t base_p1, rgb_s1, rgb_p2;

  always_comb begin
    base_p1  = base_lut[row_p1];
    rgb_s1   = '0;
    if (in_pad_p1) begin
      rgb_s1.r = scale_ch(base_p1.r, level_p1);
      rgb_s1.g = scale_ch(base_p1.g, level_p1);
      rgb_s1.b = scale_ch(base_p1.b, level_p1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) rgb_p2 <= '0;
    else       rgb_p2 <= rgb_s1;
  end

  assign bus.VGA_R = rgb_p2.r;
  assign bus.VGA_G = rgb_p2.g;
  assign bus.VGA_B = rgb_p2.b;

endmodule
